// File: rtl/div_restore_ctrl.sv
// div_restore_ctrl: control FSM and 33-bit remainder datapath for the 16-bit
// unsigned restoring divider. It drives the divisor/quotient shift stage
// (startbit, srOraddsub, iteration, operation) and consumes its shiftedD.
// Sequence: LOAD, then 17 rounds of SUB/TEST/SHIFT, then a one-cycle DONE.
// Optional build macro: DIV_ZERO_DETECT_EN. When it is defined, a zero
// divisor jumps straight to DONE and raises div_by_zero. When it is not
// defined, div_by_zero is tied low and a zero divisor runs all 17 rounds.
module div_restore_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  input  logic [31:0] shiftedD,
  output logic        startbit,
  output logic        srOraddsub,
  output logic [5:0]  iteration,
  output logic [1:0]  operation,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SUB   = 3'd2,
    TEST  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'd16;  // count before the 17th increment

  state_t      state, state_nx;
  logic [32:0] rem;
  logic [32:0] rem_diff;
  logic [32:0] rem_sum;
  logic        zero_req;

  // rem_diff is the trial subtraction. rem_sum undoes it when a borrow occurs.
  assign rem_diff  = {1'b0, rem[31:0]} - {1'b0, shiftedD};
  assign rem_sum   = rem + {1'b0, shiftedD};
  assign remainder = rem[15:0];

`ifdef DIV_ZERO_DETECT_EN
  assign zero_req = (divisor == 16'd0);

  // Divide-by-zero flag: cleared when a new operation is accepted, set when the divisor is zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_by_zero <= 1'b0;
    else if (state == IDLE && start)
      div_by_zero <= zero_req;
  end
`else
  assign zero_req    = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic and Moore outputs that go to the shift stage and the writeback logic.
  always_comb begin
    // NOTE: assign every output a default first, so no path through the case infers a latch.
    state_nx   = state;
    startbit   = 1'b0;
    srOraddsub = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_nx = zero_req ? DONE : LOAD;
      end
      LOAD: begin
        startbit = 1'b1;
        state_nx = SUB;
      end
      SUB: begin
        startbit = 1'b1;
        state_nx = TEST;
      end
      TEST: begin
        startbit = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        startbit   = 1'b1;
        srOraddsub = 1'b0;
        state_nx   = (iteration == LAST_ITER) ? DONE : SUB;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Remainder datapath, round counter and quotient-bit command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem       <= '0;
      iteration <= '0;
      operation <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rem       <= {17'b0, dividend};
            iteration <= '0;
          end
        end
        SUB: rem <= rem_diff;
        TEST: begin
          if (rem[32]) begin
            // Borrow: restore the pre-subtract value and drop the sign bit.
            rem       <= {1'b0, rem_sum[31:0]};
            operation <= 2'b10;
          end else begin
            operation <= 2'b01;
          end
        end
        SHIFT: begin
          operation <= 2'b00;
          iteration <= iteration + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
